// File: rtl/module_ctrl_uart_if.sv
// Bus and UART-core signals of the UART control block, named from the
// controller's point of view (_i driven into it, _o driven by it).
interface module_ctrl_uart_if;
    logic        we_i;
    logic [1:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_done_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;

    modport master (
        output we_i, addr_i, data_i, tx_done_i, rx_data_i, rx_valid_i,
        input  data_o, tx_start_o, tx_data_o
    );

    modport slave (
        input  we_i, addr_i, data_i, tx_done_i, rx_data_i, rx_valid_i,
        output data_o, tx_start_o, tx_data_o
    );
endinterface

// File: rtl/module_ctrl_uart.sv
// Register-mapped UART controller: CTRL/TXDATA/RXDATA registers and a
// send sequencer that pulses the TX core and waits (bounded) for done.
//
// state  | meaning
// IDLE   | waiting for SEND=1, TXDATA writable
// START  | one-cycle tx_start_o pulse, timeout counter cleared
// WAIT   | waiting for tx_done_i or timeout
// FINISH | clear SEND, return to IDLE
module module_ctrl_uart #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
    input logic               clk_i,
    input logic               rst_ni,
    module_ctrl_uart_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        send_q, send_d;
    logic        new_rx_q, new_rx_d;
    logic        tx_err_q, tx_err_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic [7:0]  txdata_q, txdata_d;
    logic [7:0]  rxdata_q, rxdata_d;

    logic        wr_ctrl;
    logic        wr_txdata;
    logic        timeout;
    logic        unused_data_hi;

    assign wr_ctrl        = bus.we_i && (bus.addr_i == 2'd0);
    assign wr_txdata      = bus.we_i && (bus.addr_i == 2'd1);
    assign unused_data_hi = ^bus.data_i[31:8];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            send_q   <= 1'b0;
            new_rx_q <= 1'b0;
            tx_err_q <= 1'b0;
            rx_ovr_q <= 1'b0;
            txdata_q <= '0;
            rxdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            send_q   <= send_d;
            new_rx_q <= new_rx_d;
            tx_err_q <= tx_err_d;
            rx_ovr_q <= rx_ovr_d;
            txdata_q <= txdata_d;
            rxdata_q <= rxdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_q) state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done on the limit cycle is a success, so it is tested first
                if (bus.tx_done_i) begin
                    state_d = FINISH;
                end else if (cnt_q == TIMEOUT_CYC - 32'd1) begin
                    timeout = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        send_d   = send_q;
        new_rx_d = new_rx_q;
        tx_err_d = tx_err_q;
        rx_ovr_d = rx_ovr_q;
        txdata_d = txdata_q;
        rxdata_d = rxdata_q;

        if (state_q == IDLE && wr_ctrl)   send_d   = bus.data_i[0];
        if (state_q == FINISH)            send_d   = 1'b0;
        if (state_q == IDLE && wr_txdata) txdata_d = bus.data_i[7:0];

        // hardware set events are applied after software clears so they win
        if (wr_ctrl && !bus.data_i[1]) new_rx_d = 1'b0;
        if (wr_ctrl && !bus.data_i[2]) tx_err_d = 1'b0;
        if (wr_ctrl && !bus.data_i[3]) rx_ovr_d = 1'b0;

        if (timeout) tx_err_d = 1'b1;

        if (bus.rx_valid_i) begin
            rxdata_d = bus.rx_data_i;
            new_rx_d = 1'b1;
            if (new_rx_q) rx_ovr_d = 1'b1;
        end
    end

    always_comb begin
        bus.data_o = '0;
        case (bus.addr_i)
            2'd0:    bus.data_o = {28'd0, rx_ovr_q, tx_err_q, new_rx_q, send_q};
            2'd1:    bus.data_o = {24'd0, txdata_q};
            2'd2:    bus.data_o = {24'd0, rxdata_q};
            default: bus.data_o = '0;
        endcase
    end

    assign bus.tx_start_o = (state_q == START);
    assign bus.tx_data_o  = txdata_q;

endmodule

// File: tb/tb_module_ctrl_uart.sv
// Directed bench for module_ctrl_uart: register vector table plus
// hand-written TX, timeout and mid-transfer reset sequences.
module tb_module_ctrl_uart;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   start_cnt = 0;
    int   sc_before;

    module_ctrl_uart_if b ();
    module_ctrl_uart_if t ();

    module_ctrl_uart dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (b.slave)
    );

    module_ctrl_uart #(.TIMEOUT_CYC(32'd8)) dut_to (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (t.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (b.tx_start_o === 1'b1) start_cnt++;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd_b(input string nm, input logic [1:0] a, input logic [31:0] exp);
        b.addr_i = a;
        #1;
        chk(nm, b.data_o, exp);
    endtask

    task automatic rd_t(input string nm, input logic [31:0] exp);
        t.addr_i = 2'd0;
        #1;
        chk(nm, t.data_o, exp);
    endtask

    initial begin
        vecs[0]  = '{"wr_txdata",     1, 2'd1, 32'h0000_00A5, 0, 8'h00, 2'd1, 32'hA5};
        vecs[1]  = '{"wr_addr3",      1, 2'd3, 32'hFFFF_FFFF, 0, 8'h00, 2'd3, 32'h0};
        vecs[2]  = '{"wr_rxdata_ro",  1, 2'd2, 32'h0000_0077, 0, 8'h00, 2'd2, 32'h0};
        vecs[3]  = '{"ctrl_hi_bits",  1, 2'd0, 32'hFFFF_FFF0, 0, 8'h00, 2'd0, 32'h0};
        vecs[4]  = '{"ctrl_w1_noeff", 1, 2'd0, 32'h0000_000E, 0, 8'h00, 2'd0, 32'h0};
        vecs[5]  = '{"rx_41_data",    0, 2'd0, 32'h0,         1, 8'h41, 2'd2, 32'h41};
        vecs[6]  = '{"rx_41_newrx",   0, 2'd0, 32'h0,         0, 8'h00, 2'd0, 32'h2};
        vecs[7]  = '{"rx_42_ovr",     0, 2'd0, 32'h0,         1, 8'h42, 2'd0, 32'hA};
        vecs[8]  = '{"rx_42_data",    0, 2'd0, 32'h0,         0, 8'h00, 2'd2, 32'h42};
        vecs[9]  = '{"ctrl_clear",    1, 2'd0, 32'h0,         0, 8'h00, 2'd0, 32'h0};
        vecs[10] = '{"rx_vs_clear",   1, 2'd0, 32'h0,         1, 8'h43, 2'd0, 32'h2};
        vecs[11] = '{"newrx_w1_keep", 1, 2'd0, 32'h0000_0002, 0, 8'h00, 2'd0, 32'h2};
        vecs[12] = '{"ovr_w1_noset",  1, 2'd0, 32'h0000_0008, 0, 8'h00, 2'd0, 32'h0};
        vecs[13] = '{"txdata_8bit",   1, 2'd1, 32'h0000_01A5, 0, 8'h00, 2'd1, 32'hA5};

        b.we_i = 1'b1; b.addr_i = 2'd0; b.data_i = 32'hF;
        b.tx_done_i = 1'b0; b.rx_data_i = 8'h00; b.rx_valid_i = 1'b0;
        t.we_i = 1'b0; t.addr_i = 2'd0; t.data_i = 32'h0;
        t.tx_done_i = 1'b0; t.rx_data_i = 8'h00; t.rx_valid_i = 1'b0;

        // reset held two cycles while a CTRL write is presented
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        b.we_i = 1'b0;
        rd_b("rst_ctrl", 2'd0, 32'h0);
        rd_b("rst_rxdata", 2'd2, 32'h0);
        chk("rst_no_start", start_cnt, 0);

        for (int i = 0; i < 14; i++) begin
            b.we_i = vecs[i].we; b.addr_i = vecs[i].addr; b.data_i = vecs[i].wdata;
            b.rx_valid_i = vecs[i].rxv; b.rx_data_i = vecs[i].rxd;
            step();
            b.we_i = 1'b0; b.rx_valid_i = 1'b0;
            rd_b(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end
        chk("tx_data_o", {24'd0, b.tx_data_o}, 32'hA5);

        // normal send
        b.we_i = 1'b1; b.addr_i = 2'd0; b.data_i = 32'h1;
        step();
        b.we_i = 1'b0;
        chk("start_not_yet", {31'd0, b.tx_start_o}, 32'h0);
        rd_b("send_set", 2'd0, 32'h1);
        step();
        chk("start_pulse", {31'd0, b.tx_start_o}, 32'h1);
        step();
        chk("start_single", {31'd0, b.tx_start_o}, 32'h0);
        b.we_i = 1'b1; b.addr_i = 2'd1; b.data_i = 32'h3C;
        step();
        b.addr_i = 2'd0; b.data_i = 32'h0;
        step();
        b.we_i = 1'b0;
        chk("busy_txdata", {24'd0, b.tx_data_o}, 32'hA5);
        rd_b("busy_send", 2'd0, 32'h1);
        repeat (6) step();
        b.tx_done_i = 1'b1;
        step();
        b.tx_done_i = 1'b0;
        rd_b("finish_send", 2'd0, 32'h1);
        step();
        rd_b("done_clear", 2'd0, 32'h0);
        repeat (3) step();
        chk("one_start", start_cnt, 1);
        b.tx_done_i = 1'b1;
        step();
        b.tx_done_i = 1'b0;
        step();
        chk("idle_done_ign", start_cnt, 1);
        rd_b("idle_done_ctrl", 2'd0, 32'h0);

        // timeout, with a clear of TX_ERR on the same edge as the timeout
        t.we_i = 1'b1; t.data_i = 32'h1;
        step();
        t.we_i = 1'b0;
        repeat (9) step();
        rd_t("to_before", 32'h1);
        t.we_i = 1'b1; t.data_i = 32'h0;
        step();
        t.we_i = 1'b0;
        rd_t("to_set_wins", 32'h5);
        step();
        rd_t("to_finish", 32'h4);
        t.we_i = 1'b1; t.data_i = 32'h0;
        step();
        t.we_i = 1'b0;
        rd_t("to_clear", 32'h0);

        // done on the limit cycle counts as success
        t.we_i = 1'b1; t.data_i = 32'h1;
        step();
        t.we_i = 1'b0;
        repeat (9) step();
        t.tx_done_i = 1'b1;
        step();
        t.tx_done_i = 1'b0;
        rd_t("lim_done_fin", 32'h1);
        step();
        rd_t("lim_done_ok", 32'h0);

        // reset during WAIT
        b.we_i = 1'b1; b.addr_i = 2'd0; b.data_i = 32'h1;
        step();
        b.we_i = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rd_b("mid_rst_ctrl", 2'd0, 32'h0);
        rd_b("mid_rst_txd", 2'd1, 32'h0);
        chk("mid_rst_start", {31'd0, b.tx_start_o}, 32'h0);
        sc_before = start_cnt;
        chk("mid_rst_cnt", sc_before, 2);
        b.tx_done_i = 1'b1;
        step();
        b.tx_done_i = 1'b0;
        repeat (3) step();
        rd_b("post_rst_ctrl", 2'd0, 32'h0);
        chk("post_rst_nostart", start_cnt, sc_before);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/module_ctrl_uart.md
Name: module_ctrl_uart

Overview:
- Register-mapped control FSM for the UART peripheral.
- Holds the control/status, TX data and RX data registers.
- Sequences one byte transmission per software "send" request: start pulse, wait for done, clear send.
- Captures received bytes with new-data and overrun flags.
- Sits between the processor bus (we_i/addr_i/data_i/data_o) and the UART TX/RX cores.

Parameters:
- TIMEOUT_CYC, 32'd100000: maximum cycles spent waiting for tx_done_i before aborting with an error.

Ports:
- clk_i  input  1  system clock, all logic on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- we_i  input  1  bus write enable, one write per cycle high
- addr_i  input  2  word select: 0 = CTRL, 1 = TXDATA, 2 = RXDATA, 3 = unused
- data_i  input  32  bus write data
- data_o  output  32  bus read data, combinational on addr_i
- tx_start_o  output  1  one-cycle start pulse to the UART TX core
- tx_data_o  output  8  byte to transmit, equals the TXDATA register
- tx_done_i  input  1  TX core finished the byte (single-cycle pulse)
- rx_data_i  input  8  byte from the UART RX core
- rx_valid_i  input  1  rx_data_i valid this cycle (single-cycle pulse)

Behaviour:

Reset (rst_ni=0 at a rising edge):
- CTRL=0, TXDATA=0, RXDATA=0, timeout counter=0, FSM=IDLE.
- tx_start_o=0, tx_data_o=0.
- Reset has priority over every other event, including mid-transmission; no further tx_start_o after it.

CTRL bits; bits 31:4 read 0, writes to them ignored:
- bit0 SEND: SW writes 1 to request; HW clears in FINISH.
- bit1 NEW_RX: HW sets on rx_valid_i; SW clears by writing 0; writing 1 has no effect.
- bit2 TX_ERR: sticky, set on timeout; SW clears by writing 0; writing 1 has no effect.
- bit3 RX_OVR: set when rx_valid_i arrives while NEW_RX=1; SW clears by writing 0.

Registers:
- TXDATA: write takes data_i[7:0], accepted only in IDLE; ignored otherwise.
- RXDATA: read-only; bus writes are ignored.
- Reads:
  - data_o = zero-extended register selected by addr_i.
  - addr 3 reads 0; writes to addr 3 are ignored.

FSM (Moore), states IDLE, START, WAIT, FINISH:
- IDLE: SEND=1 -> START.
- START: tx_start_o=1 for exactly this cycle; counter cleared; -> WAIT.
- WAIT:
  - tx_done_i=1 -> FINISH.
  - Otherwise counter+1; counter==TIMEOUT_CYC-1 without done -> set TX_ERR, -> FINISH.
  - tx_done_i on the same cycle as the limit counts as success; TX_ERR stays unchanged.
- FINISH: SEND cleared; -> IDLE.
- tx_done_i outside WAIT is ignored.

Latency:
- Write of SEND=1 at edge E0 -> START after E1 -> tx_start_o high between E1 and E2.
- tx_done_i sampled at edge Ek -> SEND reads 0 after Ek+1.

Writes while not IDLE:
- Writing SEND=0 cannot abort a transfer; SEND bit writes are ignored.
- NEW_RX/TX_ERR/RX_OVR clears are still honoured.

RX path:
- rx_valid_i=1 -> RXDATA<=rx_data_i and NEW_RX<=1 on the same edge, in any FSM state.
- Overrun: RXDATA is overwritten and RX_OVR set.
- rx_valid_i and a SW clear of NEW_RX on the same cycle: HW set wins, NEW_RX=1.
- Same rule for TX_ERR: a timeout and a SW clear on the same cycle leave TX_ERR=1.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with we_i=1, data_i=32'hF -> after release CTRL=0, RXDATA=0, tx_start_o never asserted.
- Normal TX:
  - Write TXDATA=8'hA5, then CTRL=1 -> tx_data_o=8'hA5, single tx_start_o pulse 1 cycle after the SEND write edge.
  - tx_done_i 10 cycles later -> CTRL reads 0 two edges after done; exactly one start pulse.
- Write-while-busy: during WAIT, write TXDATA=8'h3C and CTRL=0 -> tx_data_o stays 8'hA5, SEND stays 1 until tx_done_i.
- Timeout: TIMEOUT_CYC=8, SEND=1, no tx_done_i -> FINISH after 8 WAIT cycles, CTRL=4'b0100; then write CTRL=0 -> CTRL=0.
- RX and overrun:
  - rx_valid_i with 8'h41 -> RXDATA=8'h41, NEW_RX=1.
  - Second rx_valid_i with 8'h42 -> RXDATA=8'h42, RX_OVR=1.
  - rx_valid_i coincident with a CTRL write of 0 -> NEW_RX reads 1.
- Mid-transfer reset: assert rst_ni=0 during WAIT -> FSM IDLE, SEND=0; a later tx_done_i causes no state change.
